// File: rtl/input_conditioner.sv
// Board input front end: 2-flop synchronisers, per-channel debounce with press/release
// pulses, and quadrature decoding of a rotary encoder into step pulses and a position.
module input_conditioner #(
    parameter int NUM_BTN       = 5,
    parameter int DB_CYCLES     = 500000,
    parameter int ROT_DB_CYCLES = 5000,
    parameter int DB_W          = 20,
    parameter int POS_W         = 8,
    parameter int POS_MAX       = 255,
    parameter int WRAP          = 1
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [NUM_BTN-1:0] iBtn,
    input  logic               iRotA,
    input  logic               iRotB,
    input  logic               iPosClear,
    output logic [NUM_BTN-1:0] oBtnLevel,
    output logic [NUM_BTN-1:0] oBtnPress,
    output logic [NUM_BTN-1:0] oBtnRelease,
    output logic               oRotCW,
    output logic               oRotCCW,
    output logic [POS_W-1:0]   oRotPos
);

    // Channels 0..NUM_BTN-1 are buttons, then rotary A, then rotary B.
    localparam int NCH   = NUM_BTN + 2;
    localparam int CH_A  = NUM_BTN;
    localparam int CH_B  = NUM_BTN + 1;

    localparam logic [DB_W-1:0]  BTN_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0]  ROT_LAST = DB_W'(ROT_DB_CYCLES - 1);
    localparam logic [DB_W-1:0]  CNT_ONE  = DB_W'(1);
    localparam logic [POS_W-1:0] POS_TOP  = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

    logic [NCH-1:0]            raw;
    logic [NCH-1:0]            meta_q, meta_d;
    logic [NCH-1:0]            sync_q, sync_d;
    logic [NCH-1:0]            level_q, level_d;
    logic [NCH-1:0][DB_W-1:0]  cnt_q, cnt_d;
    logic [NCH-1:0]            toggle;
    logic [NUM_BTN-1:0]        press_q, press_d;
    logic [NUM_BTN-1:0]        release_q, release_d;
    logic                      cw_q, cw_d;
    logic                      ccw_q, ccw_d;
    logic                      a_rise;
    logic [POS_W-1:0]          pos_q, pos_d;

    assign raw = {iRotB, iRotA, iBtn};

    // NOTE: every variable written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        meta_d  = raw;
        sync_d  = meta_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        toggle  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (sync_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == ((i < NUM_BTN) ? BTN_LAST : ROT_LAST)) begin
                toggle[i]  = 1'b1;
                level_d[i] = ~level_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Pulses are registered alongside the level so they line up with it exactly.
    always_comb begin
        press_d   = toggle[NUM_BTN-1:0] & ~level_q[NUM_BTN-1:0];
        release_d = toggle[NUM_BTN-1:0] &  level_q[NUM_BTN-1:0];
        a_rise    = toggle[CH_A] & ~level_q[CH_A];
        cw_d      = a_rise & ~level_q[CH_B];
        ccw_d     = a_rise &  level_q[CH_B];
    end

    always_comb begin
        pos_d = pos_q;
        if (iPosClear) begin
            pos_d = '0;
        end else if (cw_q) begin
            if (pos_q == POS_TOP) pos_d = (WRAP != 0) ? '0 : POS_TOP;
            else                  pos_d = pos_q + POS_ONE;
        end else if (ccw_q) begin
            if (pos_q == '0) pos_d = (WRAP != 0) ? POS_TOP : '0;
            else             pos_d = pos_q - POS_ONE;
        end
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so the
    // synchroniser stages shift by one each edge instead of collapsing into one.
    // NOTE: debounce counters are reset too, so a count in flight when reset hits can
    // never complete afterwards.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            meta_q    <= '0;
            sync_q    <= '0;
            level_q   <= '0;
            cnt_q     <= '0;
            press_q   <= '0;
            release_q <= '0;
            cw_q      <= 1'b0;
            ccw_q     <= 1'b0;
            pos_q     <= '0;
        end else begin
            meta_q    <= meta_d;
            sync_q    <= sync_d;
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            cw_q      <= cw_d;
            ccw_q     <= ccw_d;
            pos_q     <= pos_d;
        end
    end

    assign oBtnLevel   = level_q[NUM_BTN-1:0];
    assign oBtnPress   = press_q;
    assign oBtnRelease = release_q;
    assign oRotCW      = cw_q;
    assign oRotCCW     = ccw_q;
    assign oRotPos     = pos_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Table-driven bench for input_conditioner: one wrapping and one saturating instance
// share all inputs; every cycle compares both against hand-computed expectations.
module tb_input_conditioner;

    logic       Clock;
    logic       Reset;
    logic [4:0] iBtn;
    logic       iRotA;
    logic       iRotB;
    logic       iPosClear;

    logic [4:0] w_level, w_press, w_rel;
    logic       w_cw, w_ccw;
    logic [3:0] w_pos;
    logic [4:0] s_level, s_press, s_rel;
    logic       s_cw, s_ccw;
    logic [3:0] s_pos;

    input_conditioner #(
        .NUM_BTN(5), .DB_CYCLES(4), .ROT_DB_CYCLES(4), .DB_W(4),
        .POS_W(4), .POS_MAX(9), .WRAP(1)
    ) dut_wrap (
        .Clock(Clock), .Reset(Reset), .iBtn(iBtn), .iRotA(iRotA), .iRotB(iRotB),
        .iPosClear(iPosClear), .oBtnLevel(w_level), .oBtnPress(w_press),
        .oBtnRelease(w_rel), .oRotCW(w_cw), .oRotCCW(w_ccw), .oRotPos(w_pos)
    );

    input_conditioner #(
        .NUM_BTN(5), .DB_CYCLES(4), .ROT_DB_CYCLES(4), .DB_W(4),
        .POS_W(4), .POS_MAX(9), .WRAP(0)
    ) dut_sat (
        .Clock(Clock), .Reset(Reset), .iBtn(iBtn), .iRotA(iRotA), .iRotB(iRotB),
        .iPosClear(iPosClear), .oBtnLevel(s_level), .oBtnPress(s_press),
        .oBtnRelease(s_rel), .oRotCW(s_cw), .oRotCCW(s_ccw), .oRotPos(s_pos)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        string      tag;
        logic       rst_n;
        logic [4:0] btn;
        logic       a;
        logic       b;
        logic       clr;
        logic [4:0] level;
        logic [4:0] press;
        logic [4:0] rel;
        logic       cw;
        logic       ccw;
        logic [3:0] pos_w;
        logic [3:0] pos_s;
    } vec_t;

    vec_t       vecs[$];
    string      cur_tag;
    logic       cur_a;
    logic       cur_b;
    logic [3:0] cur_pw;
    logic [3:0] cur_ps;
    int         n_vec;
    int         n_err;

    task automatic check(input string name, input logic [41:0] act, input logic [41:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input int n, input logic rst_n, input logic [4:0] btn,
                       input logic a, input logic b, input logic clr,
                       input logic [4:0] level, input logic [4:0] press, input logic [4:0] rel,
                       input logic cw, input logic ccw, input logic [3:0] pw, input logic [3:0] ps);
        vec_t v;
        v.tag = cur_tag; v.rst_n = rst_n; v.btn = btn; v.a = a; v.b = b; v.clr = clr;
        v.level = level; v.press = press; v.rel = rel; v.cw = cw; v.ccw = ccw;
        v.pos_w = pw; v.pos_s = ps;
        repeat (n) vecs.push_back(v);
    endtask

    task automatic quiet(input int n);
        add(n, 1'b1, 5'h00, cur_a, cur_b, 1'b0, 5'h00, 5'h00, 5'h00, 1'b0, 1'b0, cur_pw, cur_ps);
    endtask

    task automatic set_b(input logic v);
        cur_b = v;
        quiet(6);
    endtask

    // A rises and holds: pulse at edge 6, position at edge 7; then A falls and settles.
    task automatic step(input logic ccw, input logic [3:0] pw, input logic [3:0] ps, input logic clr);
        cur_a = 1'b1;
        quiet(5);
        add(1, 1'b1, 5'h00, 1'b1, cur_b, 1'b0, 5'h00, 5'h00, 5'h00, ~ccw, ccw, cur_pw, cur_ps);
        cur_pw = pw;
        cur_ps = ps;
        add(1, 1'b1, 5'h00, 1'b1, cur_b, clr, 5'h00, 5'h00, 5'h00, 1'b0, 1'b0, pw, ps);
        cur_a = 1'b0;
        quiet(6);
    endtask

    task automatic build_table();
        cur_a = 1'b0; cur_b = 1'b0; cur_pw = 4'd0; cur_ps = 4'd0;

        //  n  rst  btn    a  b  clr level  press  rel    cw ccw pw ps
        cur_tag = "reset";
        add(3, 0, 5'h1F, 0, 0, 0, 5'h00, 5'h00, 5'h00, 0, 0, 0, 0);
        cur_tag = "rst_release";
        add(5, 1, 5'h1F, 0, 0, 0, 5'h00, 5'h00, 5'h00, 0, 0, 0, 0);
        add(1, 1, 5'h1F, 0, 0, 0, 5'h1F, 5'h1F, 5'h00, 0, 0, 0, 0);
        add(1, 1, 5'h1F, 0, 0, 0, 5'h1F, 5'h00, 5'h00, 0, 0, 0, 0);
        cur_tag = "release_all";
        add(5, 1, 5'h00, 0, 0, 0, 5'h1F, 5'h00, 5'h00, 0, 0, 0, 0);
        add(1, 1, 5'h00, 0, 0, 0, 5'h00, 5'h00, 5'h1F, 0, 0, 0, 0);
        add(1, 1, 5'h00, 0, 0, 0, 5'h00, 5'h00, 5'h00, 0, 0, 0, 0);
        cur_tag = "press2";
        add(5, 1, 5'h04, 0, 0, 0, 5'h00, 5'h00, 5'h00, 0, 0, 0, 0);
        add(1, 1, 5'h04, 0, 0, 0, 5'h04, 5'h04, 5'h00, 0, 0, 0, 0);
        add(1, 1, 5'h04, 0, 0, 0, 5'h04, 5'h00, 5'h00, 0, 0, 0, 0);
        cur_tag = "glitch3";
        add(3, 1, 5'h05, 0, 0, 0, 5'h04, 5'h00, 5'h00, 0, 0, 0, 0);
        add(5, 1, 5'h04, 0, 0, 0, 5'h04, 5'h00, 5'h00, 0, 0, 0, 0);
        cur_tag = "pulse4";
        add(4, 1, 5'h06, 0, 0, 0, 5'h04, 5'h00, 5'h00, 0, 0, 0, 0);
        add(1, 1, 5'h04, 0, 0, 0, 5'h04, 5'h00, 5'h00, 0, 0, 0, 0);
        add(1, 1, 5'h04, 0, 0, 0, 5'h06, 5'h02, 5'h00, 0, 0, 0, 0);
        add(3, 1, 5'h04, 0, 0, 0, 5'h06, 5'h00, 5'h00, 0, 0, 0, 0);
        add(1, 1, 5'h04, 0, 0, 0, 5'h04, 5'h00, 5'h02, 0, 0, 0, 0);
        add(1, 1, 5'h04, 0, 0, 0, 5'h04, 5'h00, 5'h00, 0, 0, 0, 0);
        cur_tag = "rst_mid";
        add(4, 1, 5'h0C, 0, 0, 0, 5'h04, 5'h00, 5'h00, 0, 0, 0, 0);
        add(2, 0, 5'h0C, 0, 0, 0, 5'h00, 5'h00, 5'h00, 0, 0, 0, 0);
        add(5, 1, 5'h0C, 0, 0, 0, 5'h00, 5'h00, 5'h00, 0, 0, 0, 0);
        add(1, 1, 5'h0C, 0, 0, 0, 5'h0C, 5'h0C, 5'h00, 0, 0, 0, 0);
        add(1, 1, 5'h0C, 0, 0, 0, 5'h0C, 5'h00, 5'h00, 0, 0, 0, 0);
        cur_tag = "release";
        add(5, 1, 5'h00, 0, 0, 0, 5'h0C, 5'h00, 5'h00, 0, 0, 0, 0);
        add(1, 1, 5'h00, 0, 0, 0, 5'h00, 5'h00, 5'h0C, 0, 0, 0, 0);
        add(1, 1, 5'h00, 0, 0, 0, 5'h00, 5'h00, 5'h00, 0, 0, 0, 0);

        cur_tag = "rot_cw";
        step(1'b0, 4'd1, 4'd1, 1'b0);
        cur_tag = "b_alone";
        set_b(1'b1);
        cur_tag = "rot_ccw";
        step(1'b1, 4'd0, 4'd0, 1'b0);
        cur_tag = "ccw_at_0";
        step(1'b1, 4'd9, 4'd0, 1'b0);
        cur_tag = "climb";
        set_b(1'b0);
        for (int k = 1; k <= 9; k++) step(1'b0, 4'(k - 1), 4'(k), 1'b0);
        cur_tag = "cw_at_9";
        step(1'b0, 4'd9, 4'd9, 1'b0);
        step(1'b0, 4'd0, 4'd9, 1'b0);
        cur_tag = "ccw_down";
        set_b(1'b1);
        step(1'b1, 4'd9, 4'd8, 1'b0);

        cur_tag = "clear";
        add(1, 1, 5'h00, 0, 1, 1, 5'h00, 5'h00, 5'h00, 0, 0, 0, 0);
        cur_pw = 4'd0; cur_ps = 4'd0;
        set_b(1'b0);
        for (int k = 1; k <= 5; k++) step(1'b0, 4'(k), 4'(k), 1'b0);
        cur_tag = "clr_vs_cw";
        step(1'b0, 4'd0, 4'd0, 1'b1);
        cur_tag = "after_clr";
        step(1'b0, 4'd1, 4'd1, 1'b0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        Reset = 1'b0; iBtn = 5'h00; iRotA = 1'b0; iRotB = 1'b0; iPosClear = 1'b0;
        build_table();
        foreach (vecs[i]) begin
            Reset     = vecs[i].rst_n;
            iBtn      = vecs[i].btn;
            iRotA     = vecs[i].a;
            iRotB     = vecs[i].b;
            iPosClear = vecs[i].clr;
            @(posedge Clock);
            #1;
            check($sformatf("%s[%0d]", vecs[i].tag, i),
                  {w_level, w_press, w_rel, w_cw, w_ccw, w_pos,
                   s_level, s_press, s_rel, s_cw, s_ccw, s_pos},
                  {vecs[i].level, vecs[i].press, vecs[i].rel, vecs[i].cw, vecs[i].ccw, vecs[i].pos_w,
                   vecs[i].level, vecs[i].press, vecs[i].rel, vecs[i].cw, vecs[i].ccw, vecs[i].pos_s});
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
